// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave-port FSM states.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_INCR4  = 3'b011
  } hburst_e;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_reg_bank.sv
// Register file: one write port, one read port, write-to-read bypass.
module ahb_reg_bank #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [NUM_REGS];
  logic [31:0] mem_d [NUM_REGS];

  // Next-state of the storage array: single write port.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < NUM_REGS)) mem_d[waddr] = wdata;
  end

  // Storage flops, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port; a same-index write in flight is forwarded.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < NUM_REGS) rdata = mem_q[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/ahb_slave_port.sv
// AHB-Lite register slave with optional wait states, burst checking
// and a two-cycle ERROR response.
module ahb_slave_port
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hF0F0_F000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned BURST_EN    = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [7:0]  err_count
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e          state_q, state_d;
  logic [2:0]      wait_q, wait_d;
  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [IW-1:0]   dp_idx_q, dp_idx_d;
  logic            burst_open_q, burst_open_d;
  logic [2:0]      burst_type_q, burst_type_d;
  logic [2:0]      beat_q, beat_d;
  logic [31:0]     last_addr_q, last_addr_d;
  logic [7:0]      err_q, err_d;

  logic        accept, is_seq, legal, basic_ok, seq_ok, burst_ok;
  logic [5:0]  idx;
  logic        complete, wr_en;
  logic [31:0] rd_data;

  // Address-phase decode and legality.
  always_comb begin
    accept   = HSEL && HREADY && HTRANS[1];
    idx      = HADDR[7:2];
    is_seq   = (HTRANS == TRANS_SEQ);
    burst_ok = (HBURST == BURST_SINGLE) ||
               ((BURST_EN != 0) && ((HBURST == BURST_INCR) || (HBURST == BURST_INCR4)));
    basic_ok = ((HADDR & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) &&
               (32'(idx) < NUM_REGS) && (HSIZE == SIZE_WORD) &&
               burst_ok && (HADDR[1:0] == 2'b00);
    seq_ok   = burst_open_q && (HADDR == last_addr_q + 32'd4) &&
               !((burst_type_q == BURST_INCR4) && (beat_q >= 3'd4));
    legal    = basic_ok && (!is_seq || seq_ok);
  end

  // Data-phase outputs; an OKAY data phase completes in IDLE.
  always_comb begin
    complete  = (state_q == ST_IDLE) && dp_valid_q;
    wr_en     = complete && dp_write_q;
    HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    HRDATA    = (complete && !dp_write_q) ? rd_data : '0;
    err_count = err_q;
  end

  // FSM next-state, data-phase capture and burst tracking.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_idx_d     = dp_idx_q;
    burst_open_d = burst_open_q;
    burst_type_d = burst_type_q;
    beat_d       = beat_q;
    last_addr_d  = last_addr_q;
    err_d        = err_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d    = ST_IDLE;
        dp_valid_d = 1'b0;
        if (accept) begin
          dp_valid_d = legal;
          dp_write_d = HWRITE;
          dp_idx_d   = idx[IW-1:0];
          if (!legal) begin
            state_d = ST_ERR1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            wait_d  = WS_LOAD;
          end
          if (!is_seq) begin
            beat_d       = 3'd1;
            burst_open_d = legal && (HBURST != BURST_SINGLE);
            burst_type_d = HBURST;
            last_addr_d  = HADDR;
          end else begin
            if (beat_q != 3'd7) beat_d = beat_q + 3'd1;
            if (legal) last_addr_d = HADDR;
            else       burst_open_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 3'd0) state_d = ST_IDLE;
        else                wait_d  = wait_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_idx_q     <= '0;
      burst_open_q <= 1'b0;
      burst_type_q <= '0;
      beat_q       <= '0;
      last_addr_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_idx_q     <= dp_idx_d;
      burst_open_q <= burst_open_d;
      burst_type_q <= burst_type_d;
      beat_q       <= beat_d;
      last_addr_q  <= last_addr_d;
      err_q        <= err_d;
    end
  end

  ahb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IW)
  ) u_regs (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .we    (wr_en),
    .waddr (dp_idx_q),
    .wdata (HWDATA),
    .raddr (dp_idx_q),
    .rdata (rd_data)
  );

endmodule

// File: doc/ahb_slave_port.md
AHB_SLAVE_PORT -- requirements
Module: ahb_slave_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hF0F0_F000, base address of the register window.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFFF_F000, bits compared against BASE_ADDR.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers (1..64).
REQ-004 SHALL have parameter WAIT_STATES, default 0, wait cycles inserted per OKAY data phase (0..7).
REQ-005 SHALL have parameter BURST_EN, default 1; when 1, INCR and INCR4 are legal; when 0, only SINGLE is legal.
REQ-006 HCLK  in  1  single clock; all state on rising edge.
REQ-007 HRESETn  in  1  asynchronous, active-low reset.
REQ-008 HSEL  in  1  slave select.
REQ-009 HADDR  in  32  address-phase address.
REQ-010 HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 HWRITE  in  1  1=write, 0=read.
REQ-012 HSIZE  in  3  only 3'b010 (word) is legal.
REQ-013 HBURST  in  3  SINGLE=000, INCR=001, INCR4=011; all others are illegal.
REQ-014 HWDATA  in  32  write data (data phase).
REQ-015 HREADY  in  1  bus ready (previous transfer complete).
REQ-016 HRDATA  out  32  read data, valid when HREADYOUT=1 and HRESP=0.
REQ-017 HREADYOUT  out  1  data-phase completion.
REQ-018 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-019 err_count  out  8  saturating count of ERROR responses.

Function
REQ-020 A transfer SHALL be accepted when HSEL=1, HREADY=1 and HTRANS[1]=1; address, control, and register index SHALL be latched on that edge.
REQ-021 Index SHALL be HADDR[7:2]; a transfer is illegal if the masked address mismatches, the index is >= NUM_REGS, HSIZE!=010, HBURST is illegal, or HADDR[1:0]!=0.
REQ-022 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-023 IDLE SHALL drive HREADYOUT=1 and HRESP=0.
REQ-024 A legal accept SHALL go to IDLE when WAIT_STATES=0, else to WAIT.
REQ-025 An illegal accept SHALL go to ERR1.
REQ-026 WAIT SHALL hold HREADYOUT=0 and HRESP=0 for exactly WAIT_STATES cycles, then go to IDLE.
REQ-027 ERR1 SHALL drive HREADYOUT=0 and HRESP=1.
REQ-028 ERR2 SHALL drive HREADYOUT=1 and HRESP=1, then return to IDLE, or accept a new transfer in the same cycle.
REQ-029 A write SHALL commit HWDATA to reg[idx] on the edge ending the OKAY data phase; an ERROR SHALL never modify registers.
REQ-030 A read SHALL present reg[idx] on HRDATA during the completing cycle; HRDATA SHALL be 0 otherwise.
REQ-031 Back-to-back write then read of the same index SHALL return the newly written value (forwarding).
REQ-032 A new address phase SHALL be accepted in the same cycle the previous data phase completes (pipelined); no bubble is allowed.
REQ-033 A burst beat counter SHALL track INCR4: a NONSEQ loads 1, and each accepted SEQ increments it.
REQ-034 A SEQ SHALL be illegal if its address is not previous+4, if it is a 5th INCR4 beat, or if no burst is open.
REQ-035 BUSY and IDLE transfers SHALL get a zero-wait OKAY, with no register access and the beat counter unchanged.
REQ-036 err_count SHALL increment on entry to ERR1 and saturate at 8'hFF.

Reset
REQ-037 HRESETn low SHALL asynchronously force IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all registers 0, err_count 0, and the beat counter 0, including mid-WAIT or mid-ERR; in-flight writes SHALL be dropped.

Structure
REQ-038 Package ahb_pkg SHALL hold the HTRANS/HBURST/HSIZE encodings and the FSM state enum.
REQ-039 Register storage and forwarding SHALL be a sub-module ahb_reg_bank (NUM_REGS parameter, one write port, one read port).

Verification
REQ-040 Write 32'hDEADBEEF to F0F0_F004 (SINGLE, WAIT_STATES=0), then read F0F0_F004 -> HREADYOUT high each cycle, and HRDATA=DEADBEEF in the cycle after the write.
REQ-041 With WAIT_STATES=2, read F0F0_F000 -> HREADYOUT low for 2 cycles, then high with HRESP=0.
REQ-042 Access 0000_0000, HSIZE=000, or HBURST=010 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); registers unchanged; err_count +1 each.
REQ-043 INCR4 write F0F0_F000..F00C with a BUSY inserted -> 4 OKAY beats, regs 0..3 written; a 5th SEQ -> ERROR.
REQ-044 Assert HRESETn low during WAIT -> HREADYOUT=1, registers read 0, err_count 0.
